// File: rtl/serial_add16_ctrl.sv
// Nibble-serial two's-complement adder/subtractor: one shared 4-bit ripple
// adder is stepped across NIBBLES slices under a three-state controller.

module ripple4_gate (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module serial_add16_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   inA,
    input  logic [4*NIBBLES-1:0]   inB,
    input  logic                   Cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   outS2,
    output logic                   Cout0,
    output logic                   ovf
);
    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         a_nib, b_nib, sum_nib;
    logic               add_cout;
    logic               last_slice;

    ripple4_gate u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (sum_nib),
        .cout (add_cout)
    );

    // Slice mux: present the nibble pair selected by the slice counter.
    always_comb begin
        a_nib = 4'd0;
        b_nib = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = op_a_q[4*i +: 4];
                b_nib = op_b_q[4*i +: 4];
            end
        end
    end

    assign last_slice = (cnt_q == CNT_W'(NIBBLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, so Cin is replaced by the +1.
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_a_d  = inA;
                    op_b_d  = sub ? ~inB : inB;
                    carry_d = sub ? 1'b1 : Cin;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        result_d[4*i +: 4] = sum_nib;
                    end
                end
                carry_d = add_cout;
                if (last_slice) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    cout_d  = add_cout;
                    ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (sum_nib[3] != op_a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign outS2 = result_q;
    assign Cout0 = cout_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Bench for serial_add16_ctrl: cycle-level behavioural model plus directed
// literal cases and a randomized run.

module tb_serial_add16_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         Cin;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         busy;
    logic         done;
    logic [W-1:0] outS2;
    logic         Cout0;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add16_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .inA   (inA),
        .inB   (inB),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .outS2 (outS2),
        .Cout0 (Cout0),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op finishes N edges later with the full-width sum.
    int           m_left  = 0;
    bit           m_done  = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_live  = 1'b0;
    logic [W-1:0] m_s, p_s;
    logic         m_c, m_o, p_c, p_o;

    always @(posedge clk) begin : model
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic         cc;
        if (rst) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_s     = '0;
            m_c     = 1'b0;
            m_o     = 1'b0;
            m_valid = 1'b1;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
                if (m_done) begin
                    m_s     = p_s;
                    m_c     = p_c;
                    m_o     = p_o;
                    m_valid = 1'b1;
                end
            end else begin
                m_done = 1'b0;
                if (start) begin
                    bb      = sub ? ~inB : inB;
                    cc      = sub ? 1'b1 : Cin;
                    t       = {1'b0, inA} + {1'b0, bb} + {{W{1'b0}}, cc};
                    p_s     = t[W-1:0];
                    p_c     = t[W];
                    p_o     = (inA[W-1] == bb[W-1]) && (t[W-1] != inA[W-1]);
                    m_left  = N;
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            if (m_valid) begin
                check("outS2", 32'(outS2), 32'(m_s));
                check("Cout0", 32'(Cout0), 32'(m_c));
                check("ovf",   32'(ovf),   32'(m_o));
            end
        end
    end

    task automatic wait_done(input string name, output int k);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            inA = W'($urandom);
            inB = W'($urandom);
            sub = 1'($urandom);
            Cin = 1'($urandom);
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(N + 1));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int k;
        @(negedge clk);
        inA = a; inB = b; sub = s; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, k);
        check({name, "_s"}, 32'(outS2), 32'(es));
        check({name, "_c"}, 32'(Cout0), 32'(ec));
        check({name, "_o"}, 32'(ovf),   32'(eo));
    endtask

    initial begin
        int k;
        int dcount;
        rst = 1'b1; start = 1'b0; sub = 1'b0; Cin = 1'b0; inA = '0; inB = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s",    32'(outS2), 32'd0);
        check("rst_c",    32'(Cout0), 32'd0);
        check("rst_o",    32'(ovf),   32'd0);
        rst = 1'b0;

        run_op("add",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("sub57",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("novf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Start pulsed mid-RUN with other operands must be ignored.
        @(negedge clk);
        inA = 16'h1234; inB = 16'h4321; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        inA = 16'hAAAA; inB = 16'h1111; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 3;
        while (!done && k < 20) begin @(negedge clk); k++; end
        check("ign_latency", 32'(k), 32'(N + 1));
        check("ign_s", 32'(outS2), 32'h5555);

        // Back-to-back: start asserted during the DONE cycle.
        @(negedge clk);
        inA = 16'h0001; inB = 16'h0002; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", k);
        check("b2b_first_s", 32'(outS2), 32'h0003);
        inA = 16'h7FFF; inB = 16'h0001; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b_spacing", k);
        check("b2b_s", 32'(outS2), 32'h8000);
        check("b2b_o", 32'(ovf), 32'd1);

        // Reset after two RUN edges aborts with no done pulse.
        @(negedge clk);
        inA = 16'h1234; inB = 16'h4321; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s",    32'(outS2), 32'd0);
        check("abort_c",    32'(Cout0), 32'd0);
        dcount = 0;
        repeat (8) begin @(negedge clk); if (done) dcount++; end
        check("abort_nodone", 32'(dcount), 32'd0);

        // Reset and start together: start dropped.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start_busy2", 32'(busy), 32'd0);

        // Randomized traffic; the model tracks acceptance, ignores and resets.
        repeat (800) begin
            @(negedge clk);
            inA   = W'($urandom);
            inB   = W'($urandom);
            sub   = 1'($urandom);
            Cin   = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) inA = 16'h7FFF;
            if ($urandom_range(0, 9) == 0) inB = 16'h8000;
        end
        rst = 1'b0; start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: request a new operation; sampled only when accepted (REQ-011).
REQ-005 The block SHALL have port sub, input, 1: 0 = add, 1 = subtract (A - B); sampled with start.
REQ-006 The block SHALL have ports inA and inB, inputs, W each: operands; sampled with start.
REQ-007 The block SHALL have port Cin, input, 1: carry-in for add; ignored when sub=1.
REQ-008 The block SHALL have port busy, output, 1: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse marking result valid.
REQ-010 The block SHALL have ports outS2 (output, W: result), Cout0 (output, 1: final carry-out) and ovf (output, 1: two's-complement overflow).

Function
REQ-011 The block SHALL accept start only in states IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-012 On acceptance the block SHALL latch opA = inA, opB = sub ? ~inB : inB, carry = sub ? 1 : Cin, clear slice counter cnt to 0, and enter RUN.
REQ-013 The block SHALL instantiate exactly one ripple4_gate and reuse it for every slice; no other adder logic in the sum path.
REQ-014 In RUN, each cycle the adder SHALL receive opA[4*cnt+3:4*cnt], opB[4*cnt+3:4*cnt] and the carry register; on the edge, the sum nibble SHALL be written to result[4*cnt+3:4*cnt], carry <= adder carry-out, cnt <= cnt+1.
REQ-015 After the edge processing slice NIBBLES-1, the block SHALL enter DONE; done=1 for exactly that one cycle, then IDLE unless start is accepted in DONE, in which case it SHALL go directly to RUN (back-to-back).
REQ-016 Latency: done SHALL be high in the cycle following the NIBBLES-th edge after the accepting edge (4 edges for default).
REQ-017 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both registered-state decodes, no combinational path from start.
REQ-018 outS2 SHALL present the result register; Cout0 SHALL present the final carry; both SHALL hold their values from DONE until the next operation completes slice writes (intermediate nibble updates during RUN are permitted; they are valid only when done=1 and while idle afterwards).
REQ-019 ovf SHALL be registered at DONE entry as (opA[W-1] == opB[W-1]) && (sum[W-1] != opA[W-1]), and held like outS2.
REQ-020 Input changes on inA, inB, sub and Cin during RUN SHALL NOT affect the operation in progress.
REQ-021 For subtract, Cout0 = 1 SHALL mean no borrow (A >= B unsigned), Cout0 = 0 SHALL mean borrow.
REQ-022 cnt SHALL be ceil(log2(NIBBLES)) bits wide minimum and SHALL NOT wrap inside an operation.

Reset
REQ-023 While rst=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, outS2=0, Cout0=0, ovf=0, cnt=0, carry=0, opA=opB=0.
REQ-024 rst SHALL take priority over start in the same cycle; the start SHALL be dropped.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; first legal start is the edge after rst deasserts.

Verification
REQ-026 Add: inA=0x1234, inB=0x4321, Cin=0, sub=0, start 1 cycle -> busy 4 cycles, done pulse on 5th cycle, outS2=0x5555, Cout0=0, ovf=0.
REQ-027 Full carry ripple: 0xFFFF + 0x0001, Cin=0 -> outS2=0x0000, Cout0=1, ovf=0; also 0xFFFF + 0x0000, Cin=1 -> same result.
REQ-028 Subtract and overflow: 0x0005 - 0x0007 -> outS2=0xFFFE, Cout0=0, ovf=0; 0x7FFF + 0x0001 -> outS2=0x8000, ovf=1; 0x8000 - 0x0001 -> 0x7FFF, Cout0=1, ovf=1.
REQ-029 Handshake: start pulsed during RUN with different operands -> ignored, first result unchanged; start held high in DONE cycle -> next RUN begins immediately, done pulses spaced exactly 5 cycles.
REQ-030 Reset: rst asserted after 2 RUN edges of 0x1234+0x4321 -> next cycle busy=0, done=0, outS2=0, Cout0=0; no done pulse follows; rst and start together -> start ignored.
